byte_word_packer: RTL and testbench

//   Packs a byte stream (t_byte, valid/ready) into OUT_BYTES-wide words with per-lane keep and last.

---
 rtl/byte_pkg.sv | 17 +
 rtl/byte_word_packer_if.sv | 27 ++
 rtl/packer_fifo.sv | 74 +++++++
 rtl/byte_word_packer.sv | 88 ++++++++
 tb/tb_byte_word_packer.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/byte_pkg.sv
// Shared byte type and lane-mask helper for the byte-to-word packer.
package byte_pkg;

  typedef logic [7:0] t_byte;

  localparam int MAX_BYTES = 8;

  // One-hot lane for the lane-th byte of a word; big-endian fills from the top lane down.
  function automatic logic [MAX_BYTES-1:0] keep_mask(input int unsigned lane,
                                                     input logic        big_endian,
                                                     input int unsigned n_bytes);
    int unsigned pos;
    pos = big_endian ? (n_bytes - 1 - lane) : lane;
    return MAX_BYTES'(1) << pos;
  endfunction

endpackage

// File: rtl/byte_word_packer_if.sv
// Byte-in / word-out handshake bundle; master drives bytes and out_ready, slave is the packer.
interface byte_word_packer_if #(
  parameter int OUT_BYTES = 2
);
  import byte_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  t_byte                  in_data;
  logic                   in_last;
  logic                   out_valid;
  logic                   out_ready;
  logic [8*OUT_BYTES-1:0] out_data;
  logic [OUT_BYTES-1:0]   out_keep;
  logic                   out_last;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_keep, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_keep, out_last
  );

endinterface

// File: rtl/packer_fifo.sv
// Pointer/count synchronous FIFO with registered full/empty; push_rdy depends only on state.
// Read data shows the head entry, or the last popped word while empty so the output never goes X.
module packer_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_vld,
  output logic             push_rdy,
  input  logic [WIDTH-1:0] push_dat,
  output logic             pop_vld,
  input  logic             pop_rdy,
  output logic [WIDTH-1:0] pop_dat
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic             full_q;
  logic             empty_q;
  logic [WIDTH-1:0] hold_q;
  logic             push;
  logic             pop;

  assign push_rdy = !full_q;
  assign pop_vld  = !empty_q;
  assign push     = push_vld && !full_q;
  assign pop      = pop_rdy && !empty_q;
  assign pop_dat  = empty_q ? hold_q : mem[rd_ptr];

  always_comb begin
    cnt_nxt = cnt;
    case ({push, pop})
      2'b10:   cnt_nxt = cnt + CW'(1);
      2'b01:   cnt_nxt = cnt - CW'(1);
      default: cnt_nxt = cnt;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      hold_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + AW'(1);
      end
      if (pop) begin
        hold_q <= mem[rd_ptr];
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + AW'(1);
      end
      cnt     <= cnt_nxt;
      full_q  <= (cnt_nxt == FULL_CNT);
      empty_q <= (cnt_nxt == '0);
    end
  end

endmodule

// File: rtl/byte_word_packer.sv
// Packs a valid/ready byte stream into OUT_BYTES-wide words with keep/last; a completing byte
// is visible on the output the next cycle. in_ready is registered state only (FIFO not full).
module byte_word_packer
  import byte_pkg::*;
#(
  parameter int OUT_BYTES  = 2,
  parameter int FIFO_DEPTH = 2,
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  byte_word_packer_if.slave       bus
);

  localparam int DW = 8 * OUT_BYTES;
  localparam int WW = DW + OUT_BYTES + 1;
  localparam int LW = $clog2(OUT_BYTES);
  localparam logic [LW-1:0] LAST_LANE = LW'(OUT_BYTES - 1);

  logic [LW-1:0]        lane_cnt;
  logic [DW-1:0]        asm_data;
  logic [OUT_BYTES-1:0] asm_keep;
  logic [DW-1:0]        byte_word;
  logic [OUT_BYTES-1:0] lane_keep;
  logic                 run_q;
  logic                 fifo_rdy;
  logic                 accept;
  logic                 complete;
  logic [WW-1:0]        push_dat;
  logic [WW-1:0]        pop_dat;

  assign lane_keep = OUT_BYTES'(keep_mask(32'(lane_cnt), BIG_ENDIAN, OUT_BYTES));

  // Byte placement follows the keep bit, so endianness is decided in one place.
  always_comb begin
    byte_word = '0;
    for (int i = 0; i < OUT_BYTES; i++) begin
      if (lane_keep[i]) begin
        byte_word[8*i +: 8] = bus.in_data;
      end
    end
  end

  // run_q holds in_ready low until the first edge after reset release.
  assign bus.in_ready = run_q && fifo_rdy;
  assign accept       = bus.in_valid && bus.in_ready;
  assign complete     = accept && (bus.in_last || (lane_cnt == LAST_LANE));
  assign push_dat     = {asm_data | byte_word, asm_keep | lane_keep, bus.in_last};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q    <= 1'b0;
      lane_cnt <= '0;
      asm_data <= '0;
      asm_keep <= '0;
    end else begin
      run_q <= 1'b1;
      if (accept) begin
        if (complete) begin
          lane_cnt <= '0;
          asm_data <= '0;
          asm_keep <= '0;
        end else begin
          lane_cnt <= lane_cnt + LW'(1);
          asm_data <= asm_data | byte_word;
          asm_keep <= asm_keep | lane_keep;
        end
      end
    end
  end

  packer_fifo #(
    .WIDTH (WW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_vld (complete),
    .push_rdy (fifo_rdy),
    .push_dat (push_dat),
    .pop_vld  (bus.out_valid),
    .pop_rdy  (bus.out_ready),
    .pop_dat  (pop_dat)
  );

  assign {bus.out_data, bus.out_keep, bus.out_last} = pop_dat;

endmodule

// File: tb/tb_byte_word_packer.sv
// Bench for byte_word_packer: directed cases plus a random stream against a byte-queue word model.
module tb_byte_word_packer;
  import byte_pkg::*;

  localparam int N     = 2;
  localparam int DEPTH = 2;
  localparam int DW    = 8 * N;
  localparam int WW    = DW + N + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  byte_word_packer_if #(.OUT_BYTES(N)) m ();
  byte_word_packer_if #(.OUT_BYTES(N)) mb ();

  byte_word_packer #(.OUT_BYTES(N), .FIFO_DEPTH(DEPTH), .BIG_ENDIAN(1'b0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (m.slave)
  );

  byte_word_packer #(.OUT_BYTES(N), .FIFO_DEPTH(DEPTH), .BIG_ENDIAN(1'b1)) dut_be (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (mb.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: bytes of a word in arrival order; the k-th byte goes to lane k (or N-1-k).
  function automatic logic [WW-1:0] model_word(input t_byte b[$], input logic last, input bit be);
    logic [DW-1:0] d;
    logic [N-1:0]  k;
    d = '0;
    k = '0;
    for (int i = 0; i < b.size(); i++) begin
      int lane;
      lane = be ? (N - 1 - i) : i;
      d = d | (DW'(b[i]) << (8 * lane));
      k = k | N'(1 << lane);
    end
    return {d, k, last};
  endfunction

  logic [WW-1:0] exp_q[$];
  logic [WW-1:0] got_q[$];
  t_byte         cur_q[$];
  logic          prev_stall = 1'b0;
  logic [WW:0]   prev_out;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      cur_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        chk("hold_stable", {m.out_valid, m.out_data, m.out_keep, m.out_last}, prev_out);
      if (m.out_valid && m.out_ready) begin
        if (exp_q.size() == 0)
          chk("word_pending", exp_q.size(), 1);
        else
          chk("word", {m.out_data, m.out_keep, m.out_last}, exp_q.pop_front());
        got_q.push_back({m.out_data, m.out_keep, m.out_last});
      end
      if (m.in_valid && m.in_ready) begin
        cur_q.push_back(m.in_data);
        if (cur_q.size() == N || m.in_last) begin
          exp_q.push_back(model_word(cur_q, m.in_last, 1'b0));
          cur_q.delete();
        end
      end
      prev_stall = m.out_valid && !m.out_ready;
      prev_out   = {m.out_valid, m.out_data, m.out_keep, m.out_last};
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the byte was taken.
  task automatic send_byte(input t_byte d, input logic last);
    int waited;
    waited = 0;
    m.in_valid = 1'b1;
    m.in_data  = d;
    m.in_last  = last;
    @(negedge clk);
    while (!m.in_ready && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    if (!m.in_ready) chk("send_timeout", m.in_ready, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m.in_valid = 1'b0;
    m.in_last  = 1'b0;
  endtask

  bit rnd_done = 1'b0;
  int base;
  int waited;

  initial begin
    m.in_valid  = 1'b0; m.in_data  = '0; m.in_last  = 1'b0; m.out_ready  = 1'b0;
    mb.in_valid = 1'b0; mb.in_data = '0; mb.in_last = 1'b0; mb.out_ready = 1'b1;

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", m.out_valid, 0);
    chk("rst_in_ready",  m.in_ready,  0);
    chk("rst_out_data",  m.out_data,  0);
    chk("rst_out_keep",  m.out_keep,  0);
    chk("rst_out_last",  m.out_last,  0);
    rst_n = 1'b1;
    #1;
    chk("ready_before_edge", m.in_ready, 0);
    @(posedge clk);
    #1;
    chk("ready_after_edge", m.in_ready, 1);

    // Two-byte packet, latency of one cycle after the completing accept.
    m.out_ready = 1'b1;
    send_byte(8'h11, 1'b0);
    chk("t1_no_early_valid", m.out_valid, 0);
    send_byte(8'h22, 1'b1);
    idle();
    chk("t1_valid", m.out_valid, 1);
    chk("t1_data",  m.out_data,  16'h2211);
    chk("t1_keep",  m.out_keep,  2'b11);
    chk("t1_last",  m.out_last,  1);

    // Big-endian instance.
    chk("be_ready", mb.in_ready, 1);
    mb.in_valid = 1'b1; mb.in_data = 8'h11; mb.in_last = 1'b0;
    @(posedge clk); #1;
    mb.in_data = 8'h22; mb.in_last = 1'b1;
    @(posedge clk); #1;
    mb.in_valid = 1'b0; mb.in_last = 1'b0;
    chk("be_valid", mb.out_valid, 1);
    chk("be_data",  mb.out_data,  16'h1122);
    chk("be_keep",  mb.out_keep,  2'b11);
    mb.in_valid = 1'b1; mb.in_data = 8'h33; mb.in_last = 1'b1;
    @(posedge clk); #1;
    mb.in_valid = 1'b0; mb.in_last = 1'b0;
    chk("be_short", {mb.out_data, mb.out_keep, mb.out_last}, {16'h3300, 2'b10, 1'b1});

    // Short packet then full packet.
    base = got_q.size();
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b1);
    idle();
    repeat (4) @(posedge clk);
    #1;
    chk("t2_count", got_q.size() - base, 2);
    chk("t2_word0", got_q[base],     {16'h00AA, 2'b01, 1'b1});
    chk("t2_word1", got_q[base + 1], {16'hCCBB, 2'b11, 1'b1});

    // Backpressure: FIFO fills after two words and the fifth byte stalls.
    m.out_ready = 1'b0;
    base = got_q.size();
    for (int i = 1; i <= 4; i++) send_byte(t_byte'(i), 1'b0);
    chk("t4_full_ready", m.in_ready, 0);
    m.in_valid = 1'b1; m.in_data = 8'h05; m.in_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("t4_stalled", m.in_ready, 0);
    chk("t4_no_pop", got_q.size() - base, 0);
    m.out_ready = 1'b1;
    send_byte(8'h05, 1'b0);
    send_byte(8'h06, 1'b0);
    idle();
    repeat (6) @(posedge clk);
    #1;
    chk("t4_count", got_q.size() - base, 3);
    chk("t4_word0", got_q[base],     {16'h0201, 2'b11, 1'b0});
    chk("t4_word1", got_q[base + 1], {16'h0403, 2'b11, 1'b0});
    chk("t4_word2", got_q[base + 2], {16'h0605, 2'b11, 1'b0});

    // Random stream with random downstream stalls.
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            idle();
            @(posedge clk);
            #1;
          end
          send_byte(t_byte'($urandom), (i == 999) || ($urandom_range(0, 4) == 0));
        end
        idle();
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          m.out_ready = $urandom_range(0, 1) == 1;
        end
      end
    join
    m.out_ready = 1'b1;
    waited = 0;
    while (exp_q.size() != 0 && waited < 100) begin
      @(posedge clk);
      waited++;
    end
    @(posedge clk);
    #1;
    chk("rnd_drained", exp_q.size(), 0);
    chk("rnd_partial", cur_q.size(), 0);

    // Reset with a word queued and a partial word assembled.
    m.out_ready = 1'b0;
    send_byte(8'h77, 1'b0);
    send_byte(8'h88, 1'b0);
    send_byte(8'h55, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("r6_out_valid", m.out_valid, 0);
    chk("r6_out_data",  m.out_data,  0);
    chk("r6_out_keep",  m.out_keep,  0);
    chk("r6_out_last",  m.out_last,  0);
    chk("r6_in_ready",  m.in_ready,  0);
    idle();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("r6_ready_back", m.in_ready, 1);
    m.out_ready = 1'b1;
    base = got_q.size();
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b1);
    idle();
    repeat (4) @(posedge clk);
    #1;
    chk("r6_count", got_q.size() - base, 1);
    chk("r6_word",  got_q[base], {16'h0201, 2'b11, 1'b1});

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "simulation time limit");
  end

endmodule
